// File: rtl/stage_buffer_pkg.sv
// Shared pipeline defines: ID/EX payload layout and the stage_buffer occupancy-update encoding.
// stage_buffer stays payload-agnostic; the ID/EX stage instantiates it with DATA_W = IDEX_PAYLOAD_W.
package stage_buffer_pkg;

   localparam int XLEN        = 32;
   localparam int ALUSEL_W    = 3;
   localparam int REG_ADDR_W  = 5;

   typedef struct packed {
      logic [ALUSEL_W-1:0]   alusel;
      logic [XLEN-1:0]       op1;
      logic [XLEN-1:0]       op2;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
      logic [REG_ADDR_W-1:0] rd;
      logic                  wreg;
      logic [XLEN-1:0]       inst;
   } idex_payload_t;

   localparam int IDEX_PAYLOAD_W = $bits(idex_payload_t);

   // Encoded as {push, pop} so the update can be selected with a single case.
   typedef enum logic [1:0] {
      SB_IDLE = 2'b00,
      SB_POP  = 2'b01,
      SB_PUSH = 2'b10,
      SB_BOTH = 2'b11
   } sb_op_e;

endpackage

// File: rtl/stage_buffer.sv
// Ready/valid circular stage buffer; with DEPTH=2 it acts as a skid buffer between pipeline stages.
// Flush empties the buffer (branch interception); out_data shows an all-zero bubble when empty.
module stage_buffer
   import stage_buffer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;
   sb_op_e            op;

   // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;
   assign op   = sb_op_e'({push, pop});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      unique case (op)
         SB_PUSH: begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
         end
         SB_POP: begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
         end
         SB_BOTH: begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         default: ;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage is never reset or cleared; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: doc/stage_buffer.md
STAGE_BUFFER -- requirements
Module: stage_buffer

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits; legal range 1..512.
REQ-002 Parameter DEPTH, default 2, number of entries; power of two, at least 2.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  discards all buffered and incoming entries (branch interception).
REQ-006 in_valid  input  1  upstream has a payload this cycle.
REQ-007 in_ready  output  1  buffer accepts a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  head entry is presented downstream.
REQ-010 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 out_data  output  DATA_W  head payload; all-zero bubble when out_valid=0.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-013 Push occurs when in_valid && in_ready && !flush at a rising edge.
REQ-014 Pop occurs when out_valid && out_ready && !flush at a rising edge.
REQ-015 in_ready = (count < DEPTH), derived from registered state only; no combinational path from out_ready or out_valid to in_ready.
REQ-016 out_valid = (count != 0), derived from registered state only.
REQ-017 When full, a same-cycle pop does not enable a push; in_ready stays 0 that cycle.
REQ-018 Storage is a circular buffer with write and read pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-019 Payloads leave in the order they arrived; none is duplicated or lost unless flushed.
REQ-020 Latency: a payload pushed at edge k is visible on out_data and out_valid after edge k when the buffer was empty; minimum one-cycle pass-through, no combinational in-to-out path.
REQ-021 Simultaneous push and pop when 0 < count < DEPTH leave count unchanged and advance both pointers.
REQ-022 out_data is forced to all-zero whenever count = 0, so an empty stage presents a bubble.
REQ-023 When flush=1 at an edge, it has priority over push and pop: count and both pointers become 0, the incoming payload is dropped, and out_valid=0 after that edge.
REQ-024 Flush with count = 0 is a legal no-op apart from zeroing the pointers.
REQ-025 Storage contents are not cleared on flush; only the occupancy state is cleared.
REQ-026 in_data is sampled only on a push; out_data is stable while out_valid=1 and no pop occurs.
REQ-027 The block imposes no requirement that in_valid stay asserted until accepted; a deasserted in_valid simply means no push.

Reset
REQ-028 While rst=1, asynchronously: count=0, both pointers=0, out_valid=0, in_ready=1, out_data=0.
REQ-029 Reset asserted mid-transfer drops all entries; the first edge after rst deasserts behaves as if the buffer is empty.
REQ-030 Storage array entries need no reset.

Structure
REQ-031 The ID/EX payload width constant (alusel, operands, immediate, PC, rd, wreg, inst concatenation) belongs in the shared defines file; stage_buffer itself stays payload-agnostic.
REQ-032 stage_buffer is one flat module; no sub-module is required.
REQ-033 Instantiating with DEPTH=2 replaces a bare pipeline register with a skid buffer that tolerates a one-cycle late downstream stall.

Verification (DATA_W=8, DEPTH=2)
REQ-034 Reset check: assert rst asynchronously between edges -> count=0, out_valid=0, in_ready=1, out_data=8'h00 immediately.
REQ-035 Fill/drain check: push 8'hA1 then 8'hB2 with out_ready=0 -> count=2 and in_ready=0; then hold out_ready=1 -> out_data 8'hA1 then 8'hB2, then 8'h00 with out_valid=0.
REQ-036 Full with pop check: count=2, in_valid=1 with in_data=8'hC3, out_ready=1 -> 8'hA1 popped, 8'hC3 not accepted, count=1.
REQ-037 Streaming check: continuous in_valid=1 and out_ready=1 over 8 payloads 8'h00..8'h07 -> output is in the same order, count stays 1, and the pointers wrap without loss.
REQ-038 Flush check: count=2 with in_valid=1, in_data=8'hD4 and flush=1 at one edge -> count=0 and out_valid=0 after that edge, and 8'hD4 never appears on out_data.
REQ-039 Flush-versus-pop check: flush=1 and out_ready=1 at the same edge -> no pop is recorded, and the next push, 8'hE5, is the next out_data.
